fft_loader: RTL and testbench



---
 rtl/fft_loader.sv | 153 +++++++++++++++
 tb/tb_fft_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_loader.sv
// Ping-pong input frame buffer for the R2 pipeline FFT: fills one bank from a
// valid/ready stream while the other bank is burst out on en_fft/cnt_fft.
module fft_loader #(
    parameter int width = 16,
    parameter int N     = 6
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic signed [width-1:0] din_re,
    input  logic signed [width-1:0] din_im,
    input  logic                    ds_busy,
    output logic                    en_fft,
    output logic [N-1:0]            cnt_fft,
    output logic signed [width-1:0] dout_re,
    output logic signed [width-1:0] dout_im,
    output logic [1:0]              bank_full
);

    localparam int          DEPTH = 1 << N;
    localparam logic [N-1:0] LAST = N'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        PREF,
        RUN
    } rd_state_t;

    logic [2*width-1:0] mem [2*DEPTH];
    logic [2*width-1:0] rd_word;

    rd_state_t      state;
    rd_state_t      state_n;
    logic           ready_en;
    logic           wr_bank;
    logic           rd_bank;
    logic [N-1:0]   wr_cnt;
    logic [N-1:0]   rd_idx;
    logic [1:0]     bank_full_n;
    logic           wr_fire;
    logic           wr_done;
    logic           rd_done;
    logic           start;

    // ready_en keeps the input closed until the first clock after reset release.
    assign din_ready = ready_en & ~bank_full[wr_bank];
    assign wr_fire   = din_valid & din_ready;
    assign wr_done   = wr_fire & (wr_cnt == LAST);
    assign rd_done   = (state == RUN) & (cnt_fft == LAST);
    assign start     = bank_full[rd_bank] & ~ds_busy;

    // NOTE: storage is deliberately not reset; validity lives in bank_full, so
    // clearing the flags is enough to discard a partial or pending frame.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_bank, wr_cnt}] <= {din_re, din_im};
        end
        rd_word <= mem[{rd_bank, rd_idx}];
    end

    // NOTE: state is updated with non-blocking assignments so every flop in the
    // design samples the pre-edge values, independent of process order.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            ready_en <= 1'b0;
            wr_bank  <= 1'b0;
            wr_cnt   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (wr_fire) begin
                wr_cnt <= wr_cnt + N'(1);
                if (wr_done) begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        bank_full_n = bank_full;
        if (wr_done) begin
            bank_full_n[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            bank_full_n[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            bank_full <= 2'b00;
            rd_bank   <= 1'b0;
        end else begin
            bank_full <= bank_full_n;
            if (rd_done) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = PREF;
            PREF:    state_n = RUN;
            RUN:     if (cnt_fft == LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Read address runs two ahead of cnt_fft: one cycle of RAM latency plus the
    // output register stage.
    always_comb begin
        rd_idx = '0;
        case (state)
            IDLE:    rd_idx = '0;
            PREF:    rd_idx = N'(1);
            RUN:     rd_idx = cnt_fft + N'(2);
            default: rd_idx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            en_fft  <= 1'b0;
            cnt_fft <= '0;
            dout_re <= '0;
            dout_im <= '0;
        end else begin
            en_fft <= (state_n == RUN);
            if (state_n == RUN) begin
                cnt_fft <= (state == RUN) ? cnt_fft + N'(1) : '0;
                dout_re <= rd_word[2*width-1:width];
                dout_im <= rd_word[width-1:0];
            end else begin
                cnt_fft <= '0;
                dout_re <= '0;
                dout_im <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fft_loader.sv
// Directed bench for fft_loader: sample k carries re=k, im=-k, so every burst
// word is predicted from the frame base index and cnt_fft.
module tb_fft_loader;

    localparam int W  = 16;
    localparam int NN = 6;
    localparam int FR = 1 << NN;

    logic          clk;
    logic          areset;
    logic          din_valid;
    logic          din_ready;
    logic [W-1:0]  din_re;
    logic [W-1:0]  din_im;
    logic          ds_busy;
    logic          en_fft;
    logic [NN-1:0] cnt_fft;
    logic [W-1:0]  dout_re;
    logic [W-1:0]  dout_im;
    logic [1:0]    bank_full;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    fft_loader #(.width(W), .N(NN)) dut (
        .clk       (clk),
        .areset    (areset),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din_re    (din_re),
        .din_im    (din_im),
        .ds_busy   (ds_busy),
        .en_fft    (en_fft),
        .cnt_fft   (cnt_fft),
        .dout_re   (dout_re),
        .dout_im   (dout_im),
        .bank_full (bank_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        areset    = 1'b0;
        din_valid = 1'b0;
        ds_busy   = 1'b0;
        repeat (3) @(negedge clk);
        areset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Offers samples start..start+count-1 in order; duty is the percent chance
    // of raising valid in an idle cycle. Returns accept-edge cycle numbers.
    task automatic feed(input int start, input int count, input int duty, input int mark,
                        output int last_acc, output int mark_acc);
        int sent;
        int iter;
        sent = 0;
        iter = 0;
        last_acc = -1;
        mark_acc = -1;
        while (sent < count && iter < 4000) begin
            @(negedge clk);
            iter++;
            if (!din_valid && int'($urandom_range(99)) < duty) begin
                din_valid = 1'b1;
                din_re    = W'(start + sent);
                din_im    = W'(-(start + sent));
            end
            if (din_valid && din_ready) begin
                if (sent == mark) mark_acc = cyc + 1;
                last_acc = cyc + 1;
                sent++;
                @(posedge clk);
                #1 din_valid = 1'b0;
            end
        end
        din_valid = 1'b0;
        n_checks++;
        if (sent != count) begin
            n_fail++;
            $display("FAIL feed_%0d: accepted %0d samples, expected %0d", start, sent, count);
        end
    endtask

    // Waits (bounded) for en_fft, then checks one full contiguous burst of
    // frame `base` and the idle cycle after it. Must be called at a negedge.
    task automatic burst_check(input int base, input int timeout, output int rise);
        int w;
        w = 0;
        rise = -1;
        while (en_fft !== 1'b1 && w < timeout) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (en_fft !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_start_%0d: en_fft=%b after %0d cycles, expected 1", base, en_fft, w);
            return;
        end
        rise = cyc;
        for (int c = 0; c < FR; c++) begin
            if (c > 0) @(negedge clk);
            n_checks++;
            if (en_fft !== 1'b1 || cnt_fft !== NN'(c) ||
                dout_re !== W'(base + c) || dout_im !== W'(-(base + c))) begin
                n_fail++;
                $display("FAIL burst_%0d_k%0d: got en=%b cnt=%0d re=%h im=%h, expected en=1 cnt=%0d re=%h im=%h",
                         base, c, en_fft, cnt_fft, dout_re, dout_im, c, W'(base + c), W'(-(base + c)));
            end
        end
        @(negedge clk);
        n_checks++;
        if ({en_fft, cnt_fft, dout_re, dout_im} !== '0) begin
            n_fail++;
            $display("FAIL burst_end_%0d: got en=%b cnt=%0d re=%h im=%h, expected all 0",
                     base, en_fft, cnt_fft, dout_re, dout_im);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        areset = 1'b0;
        #1;
        n_checks++;
        if ({en_fft, cnt_fft, dout_re, dout_im, bank_full} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got en=%b cnt=%0d re=%h im=%h full=%b, expected all 0",
                     en_fft, cnt_fft, dout_re, dout_im, bank_full);
        end
        repeat (3) @(negedge clk);
        areset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (din_ready !== 1'b1 || en_fft !== 1'b0 || bank_full !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b en=%b full=%b, expected ready=1 en=0 full=00",
                     din_ready, en_fft, bank_full);
        end
    endtask

    task automatic test_single_frame();
        int la, ma, r0;
        apply_reset();
        fork
            feed(0, FR, 100, FR - 1, la, ma);
            burst_check(0, 300, r0);
        join
        n_checks++;
        if (r0 !== la + 2) begin
            n_fail++;
            $display("FAIL single_latency: en_fft rose at cycle %0d, expected %0d", r0, la + 2);
        end
        n_checks++;
        if (bank_full !== 2'b00) begin
            n_fail++;
            $display("FAIL single_flags: got bank_full=%b, expected 00", bank_full);
        end
    endtask

    task automatic test_back_to_back();
        int la, ma, r0, r1, r2;
        apply_reset();
        fork
            feed(100, 3 * FR, 100, FR - 1, la, ma);
            begin
                burst_check(100, 300, r0);
                burst_check(100 + FR, 300, r1);
                burst_check(100 + 2 * FR, 300, r2);
            end
        join
        n_checks++;
        if (r0 !== ma + 2) begin
            n_fail++;
            $display("FAIL b2b_latency: en_fft rose at cycle %0d, expected %0d", r0, ma + 2);
        end
        n_checks++;
        if (r1 !== r0 + FR + 2 || r2 !== r1 + FR + 2) begin
            n_fail++;
            $display("FAIL b2b_gap: burst starts %0d,%0d,%0d, expected spacing %0d",
                     r0, r1, r2, FR + 2);
        end
    endtask

    task automatic test_both_full();
        int la, ma, r0, r1, r2, d;
        apply_reset();
        ds_busy = 1'b1;
        fork
            feed(1000, 3 * FR, 100, 2 * FR, la, ma);
            begin
                repeat (2 * FR + 12) @(negedge clk);
                n_checks++;
                if (bank_full !== 2'b11 || din_ready !== 1'b0 || en_fft !== 1'b0) begin
                    n_fail++;
                    $display("FAIL both_full: got full=%b ready=%b en=%b, expected full=11 ready=0 en=0",
                             bank_full, din_ready, en_fft);
                end
                d = cyc;
                ds_busy = 1'b0;
                burst_check(1000, 50, r0);
                burst_check(1000 + FR, 300, r1);
                burst_check(1000 + 2 * FR, 400, r2);
                n_checks++;
                if (r0 !== d + 2) begin
                    n_fail++;
                    $display("FAIL busy_release_latency: en_fft rose at cycle %0d, expected %0d", r0, d + 2);
                end
            end
        join
        n_checks++;
        if (ma !== r0 + FR + 1) begin
            n_fail++;
            $display("FAIL stalled_accept: sample 129 taken at cycle %0d, expected %0d", ma, r0 + FR + 1);
        end
    endtask

    task automatic test_busy_mid_burst();
        int la, ma, r0, r1, d, w;
        bit seen;
        apply_reset();
        fork
            feed(500, 2 * FR, 100, -1, la, ma);
            begin
                burst_check(500, 300, r0);
                seen = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (en_fft !== 1'b0) seen = 1'b1;
                end
                n_checks++;
                if (seen !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_withhold: en_fft went high while ds_busy=1, expected 0");
                end
                n_checks++;
                if (bank_full !== 2'b10) begin
                    n_fail++;
                    $display("FAIL busy_flags: got bank_full=%b, expected 10", bank_full);
                end
                d = cyc;
                ds_busy = 1'b0;
                burst_check(500 + FR, 50, r1);
                n_checks++;
                if (r1 !== d + 2) begin
                    n_fail++;
                    $display("FAIL busy_resume: en_fft rose at cycle %0d, expected %0d", r1, d + 2);
                end
            end
            begin
                w = 0;
                while (en_fft !== 1'b1 && w < 300) begin
                    @(negedge clk);
                    w++;
                end
                repeat (20) @(negedge clk);
                ds_busy = 1'b1;
            end
        join
    endtask

    task automatic test_gaps();
        int la, ma, r0, r1;
        apply_reset();
        fork
            feed(200, 2 * FR, 50, -1, la, ma);
            begin
                burst_check(200, 800, r0);
                burst_check(200 + FR, 800, r1);
            end
        join
    endtask

    task automatic test_reset_mid_burst();
        int la, ma, r0, w;
        apply_reset();
        fork
            feed(2000, FR, 100, -1, la, ma);
            begin
                w = 0;
                while (en_fft !== 1'b1 && w < 300) begin
                    @(negedge clk);
                    w++;
                end
                repeat (30) @(negedge clk);
                n_checks++;
                if (en_fft !== 1'b1 || cnt_fft !== NN'(30)) begin
                    n_fail++;
                    $display("FAIL pre_abort: got en=%b cnt=%0d, expected en=1 cnt=30", en_fft, cnt_fft);
                end
                areset = 1'b0;
                #1;
                n_checks++;
                if ({en_fft, cnt_fft, dout_re, dout_im, bank_full} !== '0) begin
                    n_fail++;
                    $display("FAIL abort_state: got en=%b cnt=%0d re=%h im=%h full=%b, expected all 0",
                             en_fft, cnt_fft, dout_re, dout_im, bank_full);
                end
            end
        join
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        fork
            feed(3000, FR, 100, -1, la, ma);
            burst_check(3000, 300, r0);
        join
        n_checks++;
        if (r0 !== la + 2) begin
            n_fail++;
            $display("FAIL post_abort_latency: en_fft rose at cycle %0d, expected %0d", r0, la + 2);
        end
    endtask

    initial begin
        areset    = 1'b1;
        din_valid = 1'b0;
        din_re    = '0;
        din_im    = '0;
        ds_busy   = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_both_full();
        test_busy_mid_burst();
        test_gaps();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
